// File: rtl/fft_frame_feeder.sv
// fft_frame_feeder: drains whole FRAME_LEN-sample frames from the FFT sample
// FIFO and streams them as complex AXI-stream points (imag=0) with tlast on
// the final point. A frame starts only when the FIFO already holds it all.
// Optional build macro FFT_FEEDER_FRAME_CNT_EN adds a 16-bit frame_cnt output.
module fft_frame_feeder #(
    parameter int unsigned DATA_WIDTH  = 16,
    parameter int unsigned DEPTH_WIDTH = 10,
    parameter int unsigned FRAME_LEN   = 1024,
    parameter int unsigned GAP_CYCLES  = 0
) (
    input  logic                      rd_clk,
    input  logic                      rd_rst_n,
    input  logic                      enable,
    output logic                      fifo_rd_en,
    input  logic [DATA_WIDTH-1:0]     fifo_rd_data,
    input  logic                      fifo_rd_empty,
    input  logic [DEPTH_WIDTH:0]      fifo_rd_water_level,
    output logic [2*DATA_WIDTH-1:0]   m_axis_tdata,
    output logic                      m_axis_tvalid,
    output logic                      m_axis_tlast,
    input  logic                      m_axis_tready,
    output logic                      busy,
    output logic                      frame_done
`ifdef FFT_FEEDER_FRAME_CNT_EN
    ,
    output logic [15:0]               frame_cnt
`endif
);

    localparam int unsigned CW       = DEPTH_WIDTH + 1;
    localparam int unsigned GW       = 8;
    localparam int unsigned GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        GAP    = 2'd2
    } state_t;

    state_t                state_q, state_d;
    logic [CW-1:0]         reads_left_q, reads_left_d;
    logic [CW-1:0]         beats_left_q, beats_left_d;
    logic [GW-1:0]         gap_cnt_q, gap_cnt_d;
    logic [DATA_WIDTH-1:0] buf0_q, buf0_d;
    logic [DATA_WIDTH-1:0] buf1_q, buf1_d;
    logic [1:0]            occ_q, occ_d;
    logic                  inflight_q;
    logic                  pop;
    logic                  last_pop;
    logic                  rd_en;
    logic [2:0]            fill;

    // Handshake and read-issue decode; fill counts entries that will occupy the buffer
    always_comb begin
        pop      = m_axis_tvalid & m_axis_tready;
        last_pop = pop && (beats_left_q == CW'(1));
        fill     = 3'(occ_q) + 3'(inflight_q) - 3'(pop);
        rd_en    = (state_q == STREAM) && (reads_left_q != '0) &&
                   !fifo_rd_empty && (fill < 3'd2);
    end

    assign fifo_rd_en    = rd_en;
    assign m_axis_tvalid = (occ_q != 2'd0);
    assign m_axis_tdata  = {{DATA_WIDTH{1'b0}}, buf0_q};
    assign m_axis_tlast  = m_axis_tvalid && (beats_left_q == CW'(1));
    assign frame_done    = last_pop;
    assign busy          = (state_q != IDLE);

    // Next-state and counter logic
    always_comb begin
        state_d      = state_q;
        reads_left_d = reads_left_q;
        beats_left_d = beats_left_q;
        gap_cnt_d    = gap_cnt_q;
        case (state_q)
            IDLE: begin
                if (enable && (fifo_rd_water_level >= CW'(FRAME_LEN))) begin
                    state_d      = STREAM;
                    reads_left_d = CW'(FRAME_LEN);
                    beats_left_d = CW'(FRAME_LEN);
                end
            end
            STREAM: begin
                if (rd_en) reads_left_d = reads_left_q - CW'(1);
                if (pop)   beats_left_d = beats_left_q - CW'(1);
                if (last_pop) begin
                    if (GAP_CYCLES > 0) begin
                        state_d   = GAP;
                        gap_cnt_d = GW'(GAP_LOAD);
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            GAP: begin
                if (gap_cnt_q == '0) state_d = IDLE;
                else                 gap_cnt_d = gap_cnt_q - GW'(1);
            end
            default: state_d = IDLE;
        endcase
    end

    // Two-entry skid buffer: head in buf0, returning read data lands behind it
    always_comb begin
        buf0_d = buf0_q;
        buf1_d = buf1_q;
        occ_d  = occ_q;
        if (pop) begin
            buf0_d = buf1_q;
            occ_d  = occ_q - 2'd1;
        end
        if (inflight_q) begin
            if (occ_d == 2'd0) buf0_d = fifo_rd_data;
            else               buf1_d = fifo_rd_data;
            occ_d = occ_d + 2'd1;
        end
    end

    // State, counters and skid buffer registers
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n) begin
            state_q      <= IDLE;
            reads_left_q <= '0;
            beats_left_q <= '0;
            gap_cnt_q    <= '0;
            buf0_q       <= '0;
            buf1_q       <= '0;
            occ_q        <= 2'd0;
            inflight_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            reads_left_q <= reads_left_d;
            beats_left_q <= beats_left_d;
            gap_cnt_q    <= gap_cnt_d;
            buf0_q       <= buf0_d;
            buf1_q       <= buf1_d;
            occ_q        <= occ_d;
            inflight_q   <= rd_en;
        end
    end

`ifdef FFT_FEEDER_FRAME_CNT_EN
    // Completed-frame counter, wraps naturally at 16 bits
    always_ff @(posedge rd_clk or negedge rd_rst_n) begin
        if (!rd_rst_n)       frame_cnt <= 16'd0;
        else if (frame_done) frame_cnt <= frame_cnt + 16'd1;
    end
`endif

endmodule
